// File: rtl/bno055_burst_poller.sv
// Burst reader for consecutive BNO055 registers over a single-byte read engine.
// Frames are assembled in a shadow bank and copied to the committed bank in one cycle.
module bno055_burst_poller #(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned POLL_DIV    = 2_500_000,
  parameter int unsigned TIMEOUT_CYC = 250_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_auto,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_rd_start,
  output logic [7:0]       o_rd_addr,
  input  logic             i_rd_done,
  input  logic [7:0]       i_rd_data,
  output logic [7:0]       o_sel_data,
  output logic             o_frame_valid,
  output logic [7:0]       o_frame_cnt,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned NUM_SLOTS = 1 << SEL_W;
  localparam int unsigned POLL_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_REGS - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  idx_nxt;
  logic [TMR_W-1:0]  timer;
  logic [POLL_W-1:0] poll_cnt;
  logic              pending;

  // Slots are sized to the full i_sel range; slots at or above NUM_REGS stay zero.
  logic [7:0] shadow    [NUM_SLOTS];
  logic [7:0] committed [NUM_SLOTS];

  logic tick_c;
  logic trigger_c;
  logic last_c;
  logic timeout_c;

  logic rd_start_nxt;
  logic frame_valid_nxt;
  logic busy_nxt;
  logic capture_c;
  logic commit_c;
  logic set_err_c;

  assign tick_c    = i_auto && (poll_cnt == POLL_LAST);
  assign trigger_c = i_start | tick_c | pending;
  assign last_c    = (idx == LAST_IDX);
  assign timeout_c = (timer == TMR_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and byte index; a done in the timeout cycle takes priority
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (trigger_c) begin
          state_nxt = S_ISSUE;
          idx_nxt   = '0;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_rd_done) begin
          if (last_c) begin
            state_nxt = S_COMMIT;
          end else begin
            state_nxt = S_ISSUE;
            idx_nxt   = idx + SEL_W'(1);
          end
        end else if (timeout_c) begin
          state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: strobes are computed from the next state so the registers line up with it
  always_comb begin
    rd_start_nxt    = 1'b0;
    frame_valid_nxt = 1'b0;
    busy_nxt        = 1'b0;
    capture_c       = 1'b0;
    commit_c        = 1'b0;
    set_err_c       = 1'b0;
    rd_start_nxt    = (state_nxt == S_ISSUE);
    frame_valid_nxt = (state_nxt == S_COMMIT);
    busy_nxt        = (state_nxt != S_IDLE);
    capture_c       = (state == S_WAIT) && i_rd_done;
    commit_c        = (state == S_COMMIT);
    set_err_c       = (state == S_WAIT) && !i_rd_done && timeout_c;
  end

  // Registered outputs, index, timer and the two byte banks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_start    <= 1'b0;
      o_rd_addr     <= BASE_ADDR;
      o_frame_valid <= 1'b0;
      o_frame_cnt   <= 8'h00;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
      idx           <= '0;
      timer         <= '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        shadow[k]    <= 8'h00;
        committed[k] <= 8'h00;
      end
    end else begin
      o_rd_start    <= rd_start_nxt;
      o_frame_valid <= frame_valid_nxt;
      o_busy        <= busy_nxt;
      idx           <= idx_nxt;
      if (rd_start_nxt) begin
        o_rd_addr <= BASE_ADDR + 8'(idx_nxt);
      end
      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TMR_W'(1);
      end
      if (capture_c) begin
        shadow[idx] <= i_rd_data;
      end
      if (set_err_c) begin
        o_err <= 1'b1;
      end
      if (commit_c) begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          committed[k] <= shadow[k];
        end
        o_frame_cnt <= o_frame_cnt + 8'd1;
        o_err       <= 1'b0;
      end
    end
  end

  // Poll divider and coalesced request raised while a frame is in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (!i_auto) begin
        poll_cnt <= '0;
      end else if (poll_cnt == POLL_LAST) begin
        poll_cnt <= '0;
      end else begin
        poll_cnt <= poll_cnt + POLL_W'(1);
      end
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (tick_c) begin
        pending <= 1'b1;
      end
    end
  end

  assign o_sel_data = (32'(i_sel) < NUM_REGS) ? committed[i_sel] : 8'h00;

endmodule

// File: tb/tb_bno055_burst_poller.sv
// Bench for bno055_burst_poller: two configurations, behavioural read engines,
// address/frame-count scoreboards and direct checks of timing and committed data.
module tb_bno055_burst_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] eng_byte(input logic [7:0] addr, input logic [7:0] salt);
    logic [7:0] v;
    case (addr)
      8'h00:   v = 8'hA0;
      8'h01:   v = 8'hFB;
      8'h02:   v = 8'h32;
      8'h03:   v = 8'h0F;
      default: v = addr ^ 8'h5A;
    endcase
    return v ^ salt;
  endfunction

  // DUT a: 4 regs from 00, POLL_DIV 200; DUT b: 3 regs from FE, POLL_DIV 20
  logic       a_rst = 1'b1, a_start = 1'b0, a_auto = 1'b0;
  logic [1:0] a_sel = 2'd0;
  logic       a_rd_start, a_frame_valid, a_busy, a_err;
  logic [7:0] a_rd_addr, a_sel_data, a_frame_cnt;
  logic       a_rd_done = 1'b0;
  logic [7:0] a_rd_data = 8'h00;

  logic       b_rst = 1'b1, b_start = 1'b0, b_auto = 1'b0;
  logic [1:0] b_sel = 2'd0;
  logic       b_rd_start, b_frame_valid, b_busy, b_err;
  logic [7:0] b_rd_addr, b_sel_data, b_frame_cnt;
  logic       b_rd_done = 1'b0;
  logic [7:0] b_rd_data = 8'h00;

  bno055_burst_poller #(
    .NUM_REGS(4), .BASE_ADDR(8'h00), .SEL_W(2), .POLL_DIV(200), .TIMEOUT_CYC(50)
  ) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_auto(a_auto), .i_sel(a_sel),
    .o_rd_start(a_rd_start), .o_rd_addr(a_rd_addr), .i_rd_done(a_rd_done),
    .i_rd_data(a_rd_data), .o_sel_data(a_sel_data), .o_frame_valid(a_frame_valid),
    .o_frame_cnt(a_frame_cnt), .o_busy(a_busy), .o_err(a_err)
  );

  bno055_burst_poller #(
    .NUM_REGS(3), .BASE_ADDR(8'hFE), .SEL_W(2), .POLL_DIV(20), .TIMEOUT_CYC(50)
  ) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_auto(b_auto), .i_sel(b_sel),
    .o_rd_start(b_rd_start), .o_rd_addr(b_rd_addr), .i_rd_done(b_rd_done),
    .i_rd_data(b_rd_data), .o_sel_data(b_sel_data), .o_frame_valid(b_frame_valid),
    .o_frame_cnt(b_frame_cnt), .o_busy(b_busy), .o_err(b_err)
  );

  // Read engines: respond lat cycles after the start pulse; a hangs on addr 02 when asked
  int         a_lat = 1, a_cnt = 0, b_lat = 1, b_cnt = 0;
  logic       a_hang = 1'b0;
  logic [7:0] a_salt = 8'h00, b_salt = 8'h00, a_eaddr = 8'h00, b_eaddr = 8'h00;

  always @(posedge clk) begin
    a_rd_done <= 1'b0;
    if (a_rd_start && !(a_hang && a_rd_addr == 8'h02)) begin
      if (a_lat <= 1) begin
        a_rd_done <= 1'b1;
        a_rd_data <= eng_byte(a_rd_addr, a_salt);
      end else begin
        a_cnt   <= a_lat - 1;
        a_eaddr <= a_rd_addr;
      end
    end else if (a_cnt != 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin
        a_rd_done <= 1'b1;
        a_rd_data <= eng_byte(a_eaddr, a_salt);
      end
    end
  end

  always @(posedge clk) begin
    b_rd_done <= 1'b0;
    if (b_rd_start) begin
      if (b_lat <= 1) begin
        b_rd_done <= 1'b1;
        b_rd_data <= eng_byte(b_rd_addr, b_salt);
      end else begin
        b_cnt   <= b_lat - 1;
        b_eaddr <= b_rd_addr;
      end
    end else if (b_cnt != 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin
        b_rd_done <= 1'b1;
        b_rd_data <= eng_byte(b_eaddr, b_salt);
      end
    end
  end

  // Scoreboards: expected addresses per read pulse, expected count after each commit
  logic [7:0] a_addr_q[$], a_cnt_q[$], b_addr_q[$], b_cnt_q[$];
  logic [7:0] a_exp_cnt = 8'h00, b_exp_cnt = 8'h00;
  int a_frames = 0, a_starts = 0, a_last_fv = 0, a_prev_fv = 0, b_frames = 0;
  bit a_fc_pend = 1'b0, b_fc_pend = 1'b0;

  always @(negedge clk) begin
    if (a_fc_pend) begin
      a_fc_pend = 1'b0;
      check("a_cnt_expected", 32'(a_cnt_q.size() != 0), 32'd1);
      if (a_cnt_q.size() != 0) check("a_frame_cnt", 32'(a_frame_cnt), 32'(a_cnt_q.pop_front()));
    end
    if (a_rd_start) begin
      a_starts++;
      check("a_rd_expected", 32'(a_addr_q.size() != 0), 32'd1);
      if (a_addr_q.size() != 0) check("a_rd_addr", 32'(a_rd_addr), 32'(a_addr_q.pop_front()));
    end
    if (a_frame_valid) begin
      a_frames++;
      a_prev_fv = a_last_fv;
      a_last_fv = cyc;
      a_fc_pend = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (b_fc_pend) begin
      b_fc_pend = 1'b0;
      check("b_cnt_expected", 32'(b_cnt_q.size() != 0), 32'd1);
      if (b_cnt_q.size() != 0) check("b_frame_cnt", 32'(b_frame_cnt), 32'(b_cnt_q.pop_front()));
    end
    if (b_rd_start) begin
      check("b_rd_expected", 32'(b_addr_q.size() != 0), 32'd1);
      if (b_addr_q.size() != 0) check("b_rd_addr", 32'(b_rd_addr), 32'(b_addr_q.pop_front()));
    end
    if (b_frame_valid) begin
      b_frames++;
      b_fc_pend = 1'b1;
    end
  end

  task automatic push_a(input int n, input bit frame);
    for (int i = 0; i < n; i++) a_addr_q.push_back(8'(i));
    if (frame) begin
      a_exp_cnt = a_exp_cnt + 8'd1;
      a_cnt_q.push_back(a_exp_cnt);
    end
  endtask

  task automatic push_b(input int n, input bit frame);
    logic [7:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = 8'hFE + 8'(i);
      b_addr_q.push_back(ad);
    end
    if (frame) begin
      b_exp_cnt = b_exp_cnt + 8'd1;
      b_cnt_q.push_back(b_exp_cnt);
    end
  endtask

  task automatic pulse_start(input bit use_b, output int t0);
    @(posedge clk);
    #1;
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_frames(input bit use_b, input int n, input int budget, input string tag);
    int target;
    int got;
    target = (use_b ? b_frames : a_frames) + n;
    got    = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      got = use_b ? b_frames : a_frames;
      if (got >= target) return;
    end
    check(tag, 32'(got), 32'(target));
  endtask

  task automatic check_bytes_a(input logic [7:0] salt, input bit zero);
    logic [7:0] ad;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      ad    = 8'(i);
      #1;
      check("a_sel_data", 32'(a_sel_data), zero ? 32'd0 : 32'(eng_byte(ad, salt)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int tb_done;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset values
    check("rst_a_rd_start", 32'(a_rd_start), 32'd0);
    check("rst_a_rd_addr", 32'(a_rd_addr), 32'h00);
    check("rst_b_rd_addr", 32'(b_rd_addr), 32'hFE);
    check("rst_a_frame_valid", 32'(a_frame_valid), 32'd0);
    check("rst_a_frame_cnt", 32'(a_frame_cnt), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check_bytes_a(8'h00, 1'b1);

    // Single-shot frame with a 1-cycle engine
    push_a(4, 1'b1);
    pulse_start(1'b0, t0);
    wait_frames(1'b0, 1, 60, "t1_frame_timeout");
    check("t1_latency", 32'(a_last_fv - t0), 32'd9);
    @(posedge clk);
    #1;
    check("t1_busy_after", 32'(a_busy), 32'd0);
    check_bytes_a(8'h00, 1'b0);

    // Periodic polling every 200 cycles, then disabled
    push_a(4, 1'b1);
    push_a(4, 1'b1);
    push_a(4, 1'b1);
    @(negedge clk);
    a_auto = 1'b1;
    wait_frames(1'b0, 1, 400, "t2_frame0_timeout");
    wait_frames(1'b0, 1, 400, "t2_frame1_timeout");
    check("t2_period1", 32'(a_last_fv - a_prev_fv), 32'd200);
    wait_frames(1'b0, 1, 400, "t2_frame2_timeout");
    check("t2_period2", 32'(a_last_fv - a_prev_fv), 32'd200);
    a_auto = 1'b0;
    base = a_frames;
    repeat (600) @(posedge clk);
    #1;
    check("t2_no_frames_when_off", 32'(a_frames), 32'(base));

    // Engine stalls on addr 02: timeout after 50 WAIT cycles, committed bank kept
    a_hang = 1'b1;
    push_a(3, 1'b0);
    pulse_start(1'b0, t0);
    tb_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!a_busy) begin
        tb_done = 1;
        break;
      end
    end
    check("t3_idle_reached", 32'(tb_done), 32'd1);
    check("t3_timeout_latency", 32'(cyc - t0), 32'd56);
    check("t3_err_set", 32'(a_err), 32'd1);
    check("t3_cnt_kept", 32'(a_frame_cnt), 32'(a_exp_cnt));
    check_bytes_a(8'h00, 1'b0);
    a_hang = 1'b0;
    a_salt = 8'h11;
    push_a(4, 1'b1);
    pulse_start(1'b0, t0);
    wait_frames(1'b0, 1, 60, "t3_good_frame_timeout");
    @(posedge clk);
    #1;
    check("t3_err_cleared", 32'(a_err), 32'd0);
    check_bytes_a(8'h11, 1'b0);

    // Reset during WAIT of idx 2 with a slow engine; the late done must be ignored
    a_lat = 10;
    push_a(3, 1'b0);
    base = a_starts;
    pulse_start(1'b0, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_starts >= base + 3) break;
    end
    check("t5_reached_idx2", 32'(a_starts - base), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rd_start", 32'(a_rd_start), 32'd0);
    check("t5_rd_addr", 32'(a_rd_addr), 32'h00);
    check("t5_frame_valid", 32'(a_frame_valid), 32'd0);
    check("t5_frame_cnt", 32'(a_frame_cnt), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_err", 32'(a_err), 32'd0);
    check_bytes_a(8'h00, 1'b1);
    a_rst = 1'b0;
    base = a_frames;
    repeat (30) @(posedge clk);
    #1;
    check("t5_late_done_busy", 32'(a_busy), 32'd0);
    check("t5_late_done_frames", 32'(a_frames), 32'(base));
    check("t5_late_done_cnt", 32'(a_frame_cnt), 32'd0);

    // Starts while busy are dropped; two ticks while busy give exactly one extra frame
    b_lat = 20;
    push_b(3, 1'b1);
    push_b(3, 1'b1);
    base = b_frames;
    pulse_start(1'b1, t0);
    b_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(posedge clk);
      #1;
      b_start = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
    end
    while (cyc < t0 + 50) @(posedge clk);
    #1;
    b_auto = 1'b0;
    wait_frames(1'b1, 2, 400, "t4_frames_timeout");
    repeat (200) @(posedge clk);
    #1;
    check("t4_frame_total", 32'(b_frames - base), 32'd2);
    check("t4_idle", 32'(b_busy), 32'd0);

    // Address wrap FE,FF,00 and frame counter wrap FF -> 00
    b_lat = 1;
    for (int k = 0; k < 253; k++) begin
      push_b(3, 1'b1);
      pulse_start(1'b1, t0);
      wait_frames(1'b1, 1, 40, "t6_frame_timeout");
    end
    @(posedge clk);
    #1;
    check("t6_cnt_ff", 32'(b_frame_cnt), 32'hFF);
    push_b(3, 1'b1);
    pulse_start(1'b1, t0);
    wait_frames(1'b1, 1, 40, "t6_wrap_frame_timeout");
    @(posedge clk);
    #1;
    check("t6_cnt_wrapped", 32'(b_frame_cnt), 32'h00);
    b_sel = 2'd0;
    #1;
    check("t6_sel0", 32'(b_sel_data), 32'hA4);
    b_sel = 2'd1;
    #1;
    check("t6_sel1", 32'(b_sel_data), 32'hA5);
    b_sel = 2'd2;
    #1;
    check("t6_sel2", 32'(b_sel_data), 32'hA0);
    b_sel = 2'd3;
    #1;
    check("t6_sel3_out_of_range", 32'(b_sel_data), 32'h00);

    repeat (4) @(posedge clk);
    check("a_addr_q_drained", 32'(a_addr_q.size()), 32'd0);
    check("a_cnt_q_drained", 32'(a_cnt_q.size()), 32'd0);
    check("b_addr_q_drained", 32'(b_addr_q.size()), 32'd0);
    check("b_cnt_q_drained", 32'(b_cnt_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
